cmp_stream_monitor: RTL and testbench

Parametrised, registered magnitude comparator with a valid/ready handshake, a run-time compare mode, optional signed arithmetic, and a persistence alarm. It is the next generation of the team's 4-bit comparator and mode-select mux. It accepts a stream of (a, b) operand pairs and returns registered lt/eq/gt flags plus a mode-selected result. It also counts matching samples and raises a sticky alarm after PERSIST consecutive matches. It sits between a sample source and any consumer needing threshold or equality detection.

---
 rtl/cmp_stream_monitor.sv | 129 ++++++++++++
 tb/tb_cmp_stream_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_stream_monitor.sv
// Registered lt/eq/gt comparator with a mode-selected result, a saturating match counter and a sticky persistence alarm.
// Latency 1 cycle; in_ready = !out_valid || out_ready (single output register, pass-through back-pressure).
module cmp_stream_monitor #(
    parameter int WIDTH   = 8,
    parameter bit SIGNED  = 1'b0,
    parameter int PERSIST = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             result,
    output logic             alarm,
    output logic [CNT_W-1:0] match_count
);

    localparam int RUN_W = $clog2(PERSIST + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PERSIST);
    localparam logic [RUN_W-1:0] RUN_ALM = RUN_W'(PERSIST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             accept;
    logic             lt_c, eq_c, gt_c, res_c;
    logic             out_valid_q, out_valid_d;
    logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d, res_q, res_d;
    logic             alarm_q, alarm_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        eq_c = (a == b);
        if (SIGNED) begin
            lt_c = $signed(a) < $signed(b);
        end else begin
            lt_c = a < b;
        end
        gt_c = !lt_c && !eq_c;
        case (mode)
            3'b000:  res_c = eq_c;
            3'b001:  res_c = lt_c;
            3'b010:  res_c = gt_c;
            3'b011:  res_c = !eq_c;
            3'b100:  res_c = lt_c || eq_c;
            3'b101:  res_c = gt_c || eq_c;
            3'b110:  res_c = 1'b0;
            default: res_c = 1'b1;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        res_d       = res_q;
        run_d       = run_q;
        alarm_d     = alarm_q;
        cnt_d       = cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            lt_d        = lt_c;
            eq_d        = eq_c;
            gt_d        = gt_c;
            res_d       = res_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear outranks a simultaneous accept: the sample updates the flags but is not counted.
        if (clear) begin
            run_d   = '0;
            alarm_d = 1'b0;
            cnt_d   = '0;
        end else if (accept) begin
            if (res_c) begin
                if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
                if (run_q >= RUN_ALM) alarm_d = 1'b1;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            res_q       <= 1'b0;
            run_q       <= '0;
            alarm_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            res_q       <= res_d;
            run_q       <= run_d;
            alarm_q     <= alarm_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign lt          = lt_q;
    assign eq          = eq_q;
    assign gt          = gt_q;
    assign result      = res_q;
    assign alarm       = alarm_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_cmp_stream_monitor.sv
// Directed bench: three instances share one stimulus stream (unsigned, signed, 2-bit counter).
module tb_cmp_stream_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a, b;
    logic [2:0] mode;
    logic       clear;
    logic       out_ready;

    logic        s0_in_ready, s0_out_valid, s0_lt, s0_eq, s0_gt, s0_result, s0_alarm;
    logic [15:0] s0_count;
    logic        s1_in_ready, s1_out_valid, s1_lt, s1_eq, s1_gt, s1_result, s1_alarm;
    logic [15:0] s1_count;
    logic        s2_in_ready, s2_out_valid, s2_lt, s2_eq, s2_gt, s2_result, s2_alarm;
    logic [1:0]  s2_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cmp_stream_monitor #(.WIDTH(8), .SIGNED(1'b0), .PERSIST(4), .CNT_W(16)) u_uns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s0_in_ready),
        .a(a), .b(b), .mode(mode), .clear(clear), .out_valid(s0_out_valid),
        .out_ready(out_ready), .lt(s0_lt), .eq(s0_eq), .gt(s0_gt),
        .result(s0_result), .alarm(s0_alarm), .match_count(s0_count)
    );

    cmp_stream_monitor #(.WIDTH(8), .SIGNED(1'b1), .PERSIST(4), .CNT_W(16)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s1_in_ready),
        .a(a), .b(b), .mode(mode), .clear(clear), .out_valid(s1_out_valid),
        .out_ready(out_ready), .lt(s1_lt), .eq(s1_eq), .gt(s1_gt),
        .result(s1_result), .alarm(s1_alarm), .match_count(s1_count)
    );

    cmp_stream_monitor #(.WIDTH(8), .SIGNED(1'b0), .PERSIST(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s2_in_ready),
        .a(a), .b(b), .mode(mode), .clear(clear), .out_valid(s2_out_valid),
        .out_ready(out_ready), .lt(s2_lt), .eq(s2_eq), .gt(s2_gt),
        .result(s2_result), .alarm(s2_alarm), .match_count(s2_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic [2:0] m);
        in_valid = v;
        a        = av;
        b        = bv;
        mode     = m;
    endtask

    task automatic do_clear();
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    logic [7:0] mode_exp;
    logic [6:0] alarm_exp;

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        #1;
        chk("rst_out_valid", {31'd0, s0_out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, s0_in_ready}, 32'd1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Unsigned vs signed: 0x80 vs 0x01, mode gt
        drive(1'b1, 8'h80, 8'h01, 3'b010);
        step();
        chk("uns_out_valid", {31'd0, s0_out_valid}, 32'd1);
        chk("uns_gt", {31'd0, s0_gt}, 32'd1);
        chk("uns_result", {31'd0, s0_result}, 32'd1);
        chk("sgn_lt", {31'd0, s1_lt}, 32'd1);
        chk("sgn_gt", {31'd0, s1_gt}, 32'd0);
        chk("sgn_result", {31'd0, s1_result}, 32'd0);
        do_clear();
        chk("clear_idle_out_valid", {31'd0, s0_out_valid}, 32'd0);
        chk("clear_idle_count", {16'd0, s0_count}, 32'd0);

        // Mode sweep with a == b, back-to-back accepts
        mode_exp = 8'b1011_0001;  // bit i = expected result of mode i
        for (int m = 0; m < 8; m++) begin
            drive(1'b1, 8'h3C, 8'h3C, 3'(m));
            step();
            chk($sformatf("mode%0d_result", m), {31'd0, s0_result}, {31'd0, mode_exp[m]});
            chk($sformatf("mode%0d_eq", m), {31'd0, s0_eq}, 32'd1);
            chk($sformatf("mode%0d_out_valid", m), {31'd0, s0_out_valid}, 32'd1);
        end
        chk("modes_count", {16'd0, s0_count}, 32'd4);
        chk("modes_alarm", {31'd0, s0_alarm}, 32'd0);
        do_clear();

        // Back-pressure
        drive(1'b1, 8'h05, 8'h09, 3'b001);
        step();
        chk("bp_first_lt", {31'd0, s0_lt}, 32'd1);
        chk("bp_first_count", {16'd0, s0_count}, 32'd1);
        out_ready = 1'b0;
        drive(1'b1, 8'h09, 8'h05, 3'b010);
        #1;
        chk("bp_in_ready_low", {31'd0, s0_in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_hold%0d_valid", i), {31'd0, s0_out_valid}, 32'd1);
            chk($sformatf("bp_hold%0d_lt", i), {31'd0, s0_lt}, 32'd1);
            chk($sformatf("bp_hold%0d_gt", i), {31'd0, s0_gt}, 32'd0);
            chk($sformatf("bp_hold%0d_count", i), {16'd0, s0_count}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, s0_in_ready}, 32'd1);
        step();
        chk("bp_second_gt", {31'd0, s0_gt}, 32'd1);
        chk("bp_second_lt", {31'd0, s0_lt}, 32'd0);
        chk("bp_second_valid", {31'd0, s0_out_valid}, 32'd1);
        chk("bp_second_count", {16'd0, s0_count}, 32'd2);
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        step();
        chk("bp_drain_valid", {31'd0, s0_out_valid}, 32'd0);
        chk("bp_drain_count", {16'd0, s0_count}, 32'd2);
        do_clear();

        // Persistence: match, match, mismatch, then four matches
        alarm_exp = 7'b100_0000;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) drive(1'b1, 8'h03, 8'h04, 3'b000);
            else        drive(1'b1, 8'(i + 16), 8'(i + 16), 3'b000);
            step();
            chk($sformatf("persist%0d_alarm", i), {31'd0, s0_alarm}, {31'd0, alarm_exp[i]});
        end
        chk("persist_count", {16'd0, s0_count}, 32'd6);

        // Asynchronous reset mid-handshake with outputs held
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h01, 3'b000);
        step();
        chk("prereset_valid", {31'd0, s0_out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, s0_out_valid}, 32'd0);
        chk("arst_flags", {28'd0, s0_lt, s0_eq, s0_gt, s0_result}, 32'd0);
        chk("arst_alarm", {31'd0, s0_alarm}, 32'd0);
        chk("arst_count", {16'd0, s0_count}, 32'd0);
        chk("arst_in_ready", {31'd0, s0_in_ready}, 32'd1);
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Saturation of a 2-bit counter, then clear colliding with a matching accept
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h22, 8'h22, 3'b000);
            step();
            chk($sformatf("sat%0d_count", i), {30'd0, s2_count}, (i < 3) ? 32'(i + 1) : 32'd3);
        end
        chk("sat_alarm", {31'd0, s2_alarm}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clracc_alarm", {31'd0, s2_alarm}, 32'd0);
        chk("clracc_count", {30'd0, s2_count}, 32'd0);
        chk("clracc_result", {31'd0, s2_result}, 32'd1);
        chk("clracc_valid", {31'd0, s2_out_valid}, 32'd1);
        step();
        chk("postclr_count", {30'd0, s2_count}, 32'd1);
        chk("postclr_alarm", {31'd0, s2_alarm}, 32'd0);
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
